// File: rtl/midori64_pkg.sv
// Shared Midori64 key-schedule constants, FSM state type and beta expansion helper.
package midori64_pkg;

  localparam int NUM_RK = 15;

  // Midori64 round constants: 4x4 bit matrices, row-major, MSB first.
  localparam logic [15:0] MIDORI_ALPHA [0:14] = '{
    16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
    16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
    16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_WK_IN,
    S_ROUND,
    S_WK_OUT
  } state_t;

  function automatic logic [63:0] beta_expand(input logic [15:0] a);
    logic [63:0] b;
    b = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      b[4*j] = a[j];
    end
    return b;
  endfunction

endpackage

// File: rtl/midori64_key_scheduler_key_derivation.sv
// Splits the 128-bit master key into K0/K1 and derives the whitening key WK = K0 ^ K1.
module key_derivation (
  input  logic [127:0] master_key,
  output logic [63:0]  wk,
  output logic [63:0]  mk0,
  output logic [63:0]  mk1
);

  assign mk0 = master_key[127:64];
  assign mk1 = master_key[63:0];
  assign wk  = mk0 ^ mk1;

endmodule

// File: rtl/midori64_key_scheduler.sv
// Midori64 key sequencer: WK, RK_0..RK_14, WK per block over a valid/ready stream.
// Build option: define KEY_ZEROIZE_EN to wipe the key register and key_out after the last beat.
module midori64_key_scheduler
  import midori64_pkg::*;
#(
  parameter int NUM_RK = midori64_pkg::NUM_RK,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     master_key,
  output logic [63:0]      key_out,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_is_wk,
  output logic [IDX_W-1:0] beat_idx,
  output logic             key_last,
  output logic             busy
);

  generate
    if (NUM_RK != 15) begin : g_bad_num_rk
      $error("midori64_key_scheduler: NUM_RK must be 15");
    end
    if (IDX_W < 5) begin : g_bad_idx_w
      $error("midori64_key_scheduler: IDX_W must cover 0..16");
    end
  endgenerate

  localparam logic [3:0] LAST_RC = 4'(NUM_RK - 1);

  state_t        state;
  logic [127:0]  key_reg;
  logic [3:0]    rc;
  logic [127:0]  key_src;
  logic [63:0]   wk;
  logic [63:0]   mk0;
  logic [63:0]   mk1;
  logic [3:0]    rc_next;
  logic [3:0]    alpha_idx;
  logic [63:0]   rk_next;
  logic          hs;

  // In IDLE the key register is about to be loaded, so derive WK straight from the input.
  assign key_src = (state == S_IDLE) ? master_key : key_reg;

  key_derivation u_key_derivation (
    .master_key (key_src),
    .wk         (wk),
    .mk0        (mk0),
    .mk1        (mk1)
  );

  assign hs = key_valid && key_ready;

  always_comb begin
    rc_next   = (state == S_WK_IN) ? 4'd0 : rc + 4'd1;
    alpha_idx = (rc_next > LAST_RC) ? LAST_RC : rc_next;
    rk_next   = (rc_next[0] ? mk1 : mk0) ^ beta_expand(MIDORI_ALPHA[alpha_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      key_reg   <= '0;
      rc        <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_is_wk <= 1'b0;
      beat_idx  <= '0;
      key_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_reg   <= master_key;
            key_out   <= wk;
            key_valid <= 1'b1;
            key_is_wk <= 1'b1;
            key_last  <= 1'b0;
            busy      <= 1'b1;
            beat_idx  <= '0;
            rc        <= '0;
            state     <= S_WK_IN;
          end
        end
        S_WK_IN: begin
          if (hs) begin
            key_out   <= rk_next;
            key_is_wk <= 1'b0;
            rc        <= '0;
            beat_idx  <= beat_idx + 1'b1;
            state     <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (hs) begin
            beat_idx <= beat_idx + 1'b1;
            if (rc == LAST_RC) begin
              key_out   <= wk;
              key_is_wk <= 1'b1;
              key_last  <= 1'b1;
              state     <= S_WK_OUT;
            end else begin
              rc      <= rc_next;
              key_out <= rk_next;
            end
          end
        end
        S_WK_OUT: begin
          if (hs) begin
            key_valid <= 1'b0;
            key_is_wk <= 1'b0;
            key_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
`ifdef KEY_ZEROIZE_EN
            key_reg   <= '0;
            key_out   <= '0;
`else
            key_reg   <= key_reg;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midori64_key_scheduler.sv
// Directed bench for midori64_key_scheduler with hand-expanded beta constants.
module tb_midori64_key_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] master_key = '0;
  logic         key_ready = 1'b0;
  logic [63:0]  key_out;
  logic         key_valid;
  logic         key_is_wk;
  logic [4:0]   beat_idx;
  logic         key_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // beta_i written out by hand: each alpha bit becomes one nibble LSB.
  localparam logic [63:0] BETA [0:14] = '{
    64'h0001_0101_1011_0011, 64'h0111_1000_1100_0000, 64'h1010_0100_0011_0101,
    64'h0110_0010_0001_0011, 64'h0001_0000_0100_1111, 64'h1101_0001_0111_0000,
    64'h0000_0010_0110_0110, 64'h0000_1011_1100_1100, 64'h1001_0100_1000_0001,
    64'h0100_0000_1011_1000, 64'h0111_0001_1001_0111, 64'h0010_0010_1000_1110,
    64'h0101_0001_0011_0000, 64'h1111_1000_1100_1010, 64'h1101_1111_1001_0000
  };

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEF_89ABCDEF01234567;
  localparam logic [127:0] KEY_B = 128'hDEADBEEF00000000_00000000CAFEF00D;

  midori64_key_scheduler #(.NUM_RK(15), .IDX_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .master_key (master_key),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_is_wk  (key_is_wk),
    .beat_idx   (beat_idx),
    .key_last   (key_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int b, input logic [63:0] k0, input logic [63:0] k1);
    if (b == 0 || b == 16) return k0 ^ k1;
    return ((((b - 1) % 2) == 1) ? k1 : k0) ^ BETA[b-1];
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 128'(key_valid), 128'(0));
    check({tag, "_busy"},  128'(busy),      128'(0));
    check({tag, "_out"},   128'(key_out),   128'(0));
    check({tag, "_idx"},   128'(beat_idx),  128'(0));
    check({tag, "_iswk"},  128'(key_is_wk), 128'(0));
    check({tag, "_last"},  128'(key_last),  128'(0));
    check({tag, "_kreg"},  dut.key_reg,     128'(0));
  endtask

  task automatic run_block(input string name, input logic [127:0] key, input bit rnd,
                           input int inject_at, input logic [127:0] alt_key, input int abort_at);
    logic [63:0] k0;
    logic [63:0] k1;
    int          stalls;
    bit          r;
    k0 = key[127:64];
    k1 = key[63:0];
    @(negedge clk);
    start      = 1'b1;
    master_key = key;
    key_ready  = 1'b0;
    for (int b = 0; b < 17; b++) begin
      stalls = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        if (b == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_idle_zero($sformatf("%s_rst", name));
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        check($sformatf("%s_b%0d_valid", name, b), 128'(key_valid), 128'(1));
        check($sformatf("%s_b%0d_busy", name, b),  128'(busy), 128'(1));
        check($sformatf("%s_b%0d_idx", name, b),   128'(beat_idx), 128'(b));
        check($sformatf("%s_b%0d_key", name, b),   128'(key_out), 128'(exp_beat(b, k0, k1)));
        check($sformatf("%s_b%0d_iswk", name, b),  128'(key_is_wk), 128'(b == 0 || b == 16));
        check($sformatf("%s_b%0d_last", name, b),  128'(key_last), 128'(b == 16));
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stalls >= 20) r = 1'b1;
        key_ready = r;
        if (b == inject_at && stalls == 0) begin
          start      = 1'b1;
          master_key = alt_key;
        end
        stalls++;
      end while (!r);
    end
    @(negedge clk);
    start     = 1'b0;
    key_ready = 1'b0;
    check({name, "_done_valid"}, 128'(key_valid), 128'(0));
    check({name, "_done_busy"},  128'(busy), 128'(0));
    check({name, "_done_last"},  128'(key_last), 128'(0));
`ifdef KEY_ZEROIZE_EN
    check({name, "_done_out"},  128'(key_out), 128'(0));
    check({name, "_done_kreg"}, dut.key_reg, 128'(0));
`else
    check({name, "_done_out"},  128'(key_out), 128'(k0 ^ k1));
    check({name, "_done_kreg"}, dut.key_reg, key);
`endif
    // Idle must stay idle: no stray beat without a start.
    @(negedge clk);
    check({name, "_idle_valid"}, 128'(key_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_block("t1_zero", 128'(0), 1'b0, -1, 128'(0), -1);
    run_block("t2_keyA", KEY_A, 1'b0, 16, KEY_B, -1);
    run_block("t3_rand", KEY_A, 1'b1, -1, 128'(0), -1);
    run_block("t4_inj",  KEY_A, 1'b0, 5, KEY_B, -1);
    run_block("t5_abort", KEY_A, 1'b0, -1, 128'(0), 8);
    run_block("t5_fresh", KEY_B, 1'b0, -1, 128'(0), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
